// File: rtl/mac_sequencer.sv
// mac_sequencer: walks one MAC accumulator through a full dot product.
// Clears the MAC with the latched bias, streams N_TERMS operand pairs read
// from two synchronous-read memories, issues one flush beat so the MAC's
// delayed output shows the complete sum, then captures that sum.
module mac_sequencer #(
  parameter int IN_BITWIDTH  = 16,
  parameter int OUT_BITWIDTH = 32,
  parameter int B_BITS       = 15,
  parameter int N_TERMS      = 3,
  parameter int ADDR_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_BITS-1:0]    act_base,
  input  logic [ADDR_BITS-1:0]    wgt_base,
  input  logic [B_BITS:0]         bias_in,
  output logic [ADDR_BITS-1:0]    act_addr,
  output logic [ADDR_BITS-1:0]    wgt_addr,
  input  logic [IN_BITWIDTH-1:0]  act_rdata,
  input  logic [IN_BITWIDTH-1:0]  wgt_rdata,
  output logic [IN_BITWIDTH-1:0]  mac_a_in,
  output logic [IN_BITWIDTH-1:0]  mac_w_in,
  output logic [B_BITS:0]         mac_bias,
  output logic [31:0]             mac_counter,
  output logic                    mac_en,
  output logic                    mac_rstn,
  input  logic [OUT_BITWIDTH-1:0] mac_out,
  output logic [OUT_BITWIDTH-1:0] result,
  output logic                    result_valid,
  output logic                    busy
);

  // Term index only has to span 0..N_TERMS-1.
  localparam int CNT_W = (N_TERMS < 2) ? 1 : $clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_CAPTURE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     term_q, term_d;
  logic [ADDR_BITS-1:0] act_base_q, wgt_base_q;
  logic [B_BITS:0]      bias_q;

  // State and term-index registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      term_q  <= '0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
    end
  end

  // Latch job parameters when a start is accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_base_q <= '0;
      wgt_base_q <= '0;
      bias_q     <= '0;
    end else if (state_q == S_IDLE && start) begin
      act_base_q <= act_base;
      wgt_base_q <= wgt_base;
      bias_q     <= bias_in;
    end
  end

  // Capture the MAC output during CAPTURE and pulse result_valid after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= (state_q == S_CAPTURE);
      if (state_q == S_CAPTURE) begin
        result <= mac_out;
      end
    end
  end

  // Next-state logic and the MAC/memory drive for the current state.
  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    term_d      = term_q;
    mac_en      = 1'b0;
    mac_a_in    = '0;
    mac_w_in    = '0;
    mac_counter = '0;
    act_addr    = '0;
    wgt_addr    = '0;
    // The MAC clear follows our own reset as well as the CLEAR state.
    mac_rstn    = ~rst;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        // Bias goes into the accumulator; first reads are issued so data
        // arrives in the first FEED cycle.
        mac_rstn = 1'b0;
        act_addr = act_base_q;
        wgt_addr = wgt_base_q;
        term_d   = '0;
        state_d  = S_FEED;
      end

      S_FEED: begin
        mac_en      = 1'b1;
        mac_a_in    = act_rdata;
        mac_w_in    = wgt_rdata;
        mac_counter = 32'(term_q);
        // Prefetch the next pair; addresses wrap naturally at ADDR_BITS.
        act_addr    = act_base_q + ADDR_BITS'(term_q) + ADDR_BITS'(1);
        wgt_addr    = wgt_base_q + ADDR_BITS'(term_q) + ADDR_BITS'(1);
        if (term_q == LAST_TERM) begin
          term_d  = '0;
          state_d = S_FLUSH;
        end else begin
          term_d  = term_q + CNT_W'(1);
        end
      end

      S_FLUSH: begin
        // Zero-operand beat pushes the full sum onto the MAC's delayed output.
        mac_en      = 1'b1;
        mac_counter = 32'(N_TERMS);
        state_d     = S_CAPTURE;
      end

      S_CAPTURE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mac_bias = bias_q;
  assign busy     = (state_q != S_IDLE);

endmodule
